// File: rtl/mul_share_arbiter_if.sv
// Handshake/bus bundle for mul_share_arbiter: requester operands, multiplier link,
// tagged responses and halt/drain control.
interface mul_share_arbiter_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic [2*WIDTH-1:0]    mul_z;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-1:0]    rsp_z;
   logic                  halt_req;
   logic                  halted;
   logic [IDW+1:0]        inflight;

   // System side: requesters, the multiplier product and halt control.
   modport master (
      output req_valid, req_a, req_b, mul_z, halt_req,
      input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_z, halted, inflight
   );

   modport slave (
      input  req_valid, req_a, req_b, mul_z, halt_req,
      output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_z, halted, inflight
   );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters, with ID-tagged
// responses and a halt/drain FSM. Optional macro MUL_ARB_RSP_REG_EN registers the response.
module mul_share_arbiter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned MUL_LAT = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   mul_share_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALTED
   } state_e;

   localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
   localparam logic [IDW:0]   ONE_P   = (IDW+1)'(1);
   localparam logic [IDW+1:0] ONE_INF = (IDW+2)'(1);

   state_e               state_q;
   logic                 halted_q;
   logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDW+1:0]       inflight_q, inflight_d;
   logic [MUL_LAT-1:0]   vld_q;
   logic [IDW-1:0]       id_q [MUL_LAT];

   logic [2**IDW-1:0]    vld_ext;
   logic                 found;
   logic [IDW-1:0]       win;
   logic [IDW:0]         idx;
   logic [IDW:0]         ptr_inc;
   logic                 grant_en;
   logic [NREQ-1:0]      ready;
   logic [WIDTH-1:0]     mul_a_d, mul_b_d;
   logic                 rsp_fire;

   // Rotating search starting at rr_ptr_q; vld_ext pads to a power of two for clean indexing.
   always_comb begin
      vld_ext            = '0;
      vld_ext[NREQ-1:0]  = bus.req_valid;
      found              = 1'b0;
      win                = '0;
      idx                = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
         if (idx >= NREQ_W) idx = idx - NREQ_W;
         if (!found && vld_ext[idx[IDW-1:0]]) begin
            found = 1'b1;
            win   = idx[IDW-1:0];
         end
      end
   end

   assign grant_en = found && (state_q == RUN) && !bus.halt_req;

   always_comb begin
      ready   = '0;
      mul_a_d = '0;
      mul_b_d = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (found && (win == IDW'(i))) begin
            mul_a_d  = bus.req_a[i*WIDTH +: WIDTH];
            mul_b_d  = bus.req_b[i*WIDTH +: WIDTH];
            ready[i] = grant_en;
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.mul_a     = mul_a_d;
   assign bus.mul_b     = mul_b_d;

   always_comb begin
      ptr_inc  = {1'b0, win} + ONE_P;
      rr_ptr_d = rr_ptr_q;
      if (grant_en) rr_ptr_d = (ptr_inc == NREQ_W) ? '0 : ptr_inc[IDW-1:0];
   end

   always_comb begin
      inflight_d = inflight_q;
      case ({grant_en, rsp_fire})
         2'b10:   inflight_d = inflight_q + ONE_INF;
         2'b01:   inflight_d = inflight_q - ONE_INF;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         inflight_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= inflight_d;
      end
   end

   // Tag shift register tracks the multiplier pipeline one-for-one; it never stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < MUL_LAT; i++) id_q[i] <= '0;
      end else begin
         vld_q[0] <= grant_en;
         id_q[0]  <= win;
         for (int unsigned i = 1; i < MUL_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            id_q[i]  <= id_q[i-1];
         end
      end
   end

`ifdef MUL_ARB_RSP_REG_EN
   logic               rsp_valid_q;
   logic [IDW-1:0]     rsp_id_q;
   logic [2*WIDTH-1:0] rsp_z_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_z_q     <= '0;
      end else begin
         rsp_valid_q <= vld_q[MUL_LAT-1];
         rsp_id_q    <= id_q[MUL_LAT-1];
         rsp_z_q     <= bus.mul_z;
      end
   end

   assign rsp_fire = rsp_valid_q;
   assign bus.rsp_id = rsp_id_q;
   assign bus.rsp_z  = rsp_z_q;
`else
   assign rsp_fire = vld_q[MUL_LAT-1];
   assign bus.rsp_id = id_q[MUL_LAT-1];
   assign bus.rsp_z  = bus.mul_z;
`endif

   assign bus.rsp_valid = rsp_fire;
   assign bus.inflight  = inflight_q;
   assign bus.halted    = halted_q;

   // DRAIN ignores halt_req: a drain always completes to HALTED before RUN resumes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (bus.halt_req) state_q <= DRAIN;
            end
            DRAIN: begin
               if (inflight_q == '0) begin
                  state_q  <= HALTED;
                  halted_q <= 1'b1;
               end
            end
            HALTED: begin
               if (!bus.halt_req) begin
                  state_q  <= RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= RUN;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a 2-stage multiplier model.
// Response latency follows MUL_ARB_RSP_REG_EN when defined.
module tb_mul_share_arbiter;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned NREQ    = 4;
   localparam int unsigned IDW     = 2;
   localparam int unsigned MUL_LAT = 2;
`ifdef MUL_ARB_RSP_REG_EN
   localparam int LAT = MUL_LAT + 1;
`else
   localparam int LAT = MUL_LAT;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mul_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

   mul_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Two-stage unsigned multiplier sharing rst_n.
   logic [15:0] p1, p2;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= '0;
         p2 <= '0;
      end else begin
         p1 <= {8'b0, bus.mul_a} * {8'b0, bus.mul_b};
         p2 <= p1;
      end
   end
   assign bus.mul_z = p2;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      bus.req_a[i*8 +: 8] = a;
      bus.req_b[i*8 +: 8] = b;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.halt_req  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] oa [4];
   logic [7:0] ob [4];

   initial begin
      int inf_exp, dec;
      oa[0] = 8'd10; ob[0] = 8'd3;
      oa[1] = 8'd17; ob[1] = 8'd8;
      oa[2] = 8'd200; ob[2] = 8'd13;
      oa[3] = 8'd255; ob[3] = 8'd2;

      // Reset values and single issue from requester 0: 13*11 = 143
      do_reset();
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
      chk("rst_inflight", 32'(bus.inflight), 32'h0);
      chk("rst_halted", 32'(bus.halted), 32'h0);
      chk("rst_mul_a", 32'(bus.mul_a), 32'h0);
      tick();
      bus.req_valid = 4'b0001;
      set_op(0, 8'd13, 8'd11);
      @(negedge clk);
      chk("s1_ready", 32'(bus.req_ready), 32'b0001);
      chk("s1_mul_a", 32'(bus.mul_a), 32'd13);
      chk("s1_mul_b", 32'(bus.mul_b), 32'd11);
      tick();
      bus.req_valid = '0;
      for (int k = 1; k < LAT; k++) begin
         @(negedge clk);
         chk("s1_early_rsp", 32'(bus.rsp_valid), 32'h0);
         chk("s1_inflight", 32'(bus.inflight), 32'd1);
         tick();
      end
      @(negedge clk);
      chk("s1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("s1_rsp_id", 32'(bus.rsp_id), 32'h0);
      chk("s1_rsp_z", 32'(bus.rsp_z), 32'd143);
      tick();
      @(negedge clk);
      chk("s1_rsp_end", 32'(bus.rsp_valid), 32'h0);
      chk("s1_inflight_end", 32'(bus.inflight), 32'h0);

      // All four valid: round-robin 0,1,2,3,0,... for 8 grants, then drain
      do_reset();
      for (int i = 0; i < 4; i++) set_op(i, oa[i], ob[i]);
      bus.req_valid = 4'b1111;
      for (int k = 0; k <= 8 + LAT; k++) begin
         if (k == 8) bus.req_valid = '0;
         @(negedge clk);
         chk("s2_ready", 32'(bus.req_ready), (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
         dec = k - LAT;
         if (dec < 0) dec = 0;
         if (dec > 8) dec = 8;
         inf_exp = ((k < 8) ? k : 8) - dec;
         chk("s2_inflight", 32'(bus.inflight), 32'(inf_exp));
         if (k >= LAT && k <= 7 + LAT) begin
            chk("s2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("s2_rsp_id", 32'(bus.rsp_id), 32'((k - LAT) % 4));
            chk("s2_rsp_z", 32'(bus.rsp_z),
                32'(16'(oa[(k - LAT) % 4]) * 16'(ob[(k - LAT) % 4])));
         end else begin
            chk("s2_rsp_idle", 32'(bus.rsp_valid), 32'h0);
         end
         tick();
      end

      // Boundary operands: FF*FF from requester 3, then 0*A5 from requester 0
      do_reset();
      bus.req_valid = 4'b1000;
      set_op(3, 8'hFF, 8'hFF);
      @(negedge clk);
      chk("s3_ready3", 32'(bus.req_ready), 32'b1000);
      chk("s3_mul_a", 32'(bus.mul_a), 32'hFF);
      tick();
      bus.req_valid = 4'b0001;
      set_op(0, 8'h00, 8'hA5);
      @(negedge clk);
      chk("s3_ready0", 32'(bus.req_ready), 32'b0001);
      chk("s3_mul_b", 32'(bus.mul_b), 32'hA5);
      tick();
      bus.req_valid = '0;
      for (int k = 2; k <= LAT + 2; k++) begin
         @(negedge clk);
         if (k == 2) chk("s3_nowin_mul_a", 32'(bus.mul_a), 32'h0);
         if (k == LAT) begin
            chk("s3_ff_valid", 32'(bus.rsp_valid), 32'h1);
            chk("s3_ff_id", 32'(bus.rsp_id), 32'd3);
            chk("s3_ff_z", 32'(bus.rsp_z), 32'hFE01);
         end else if (k == LAT + 1) begin
            chk("s3_zero_valid", 32'(bus.rsp_valid), 32'h1);
            chk("s3_zero_id", 32'(bus.rsp_id), 32'd0);
            chk("s3_zero_z", 32'(bus.rsp_z), 32'h0);
         end else begin
            chk("s3_idle", 32'(bus.rsp_valid), 32'h0);
         end
         tick();
      end

      // Halt/drain: issue to 1, halt next cycle, drain, then resume with requester 3
      do_reset();
      set_op(1, 8'd7, 8'd9);
      set_op(3, 8'd2, 8'd5);
      bus.req_valid = 4'b1010;
      @(negedge clk);
      chk("s4_ready1", 32'(bus.req_ready), 32'b0010);
      tick();
      bus.req_valid = 4'b1000;
      bus.halt_req  = 1'b1;
      for (int k = 1; k <= LAT + 3; k++) begin
         if (k == LAT + 3) bus.halt_req = 1'b0;
         @(negedge clk);
         chk("s4_no_grant", 32'(bus.req_ready), 32'h0);
         chk("s4_halted", 32'(bus.halted), (k >= LAT + 2) ? 32'h1 : 32'h0);
         if (k == LAT) begin
            chk("s4_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("s4_rsp_id", 32'(bus.rsp_id), 32'd1);
            chk("s4_rsp_z", 32'(bus.rsp_z), 32'd63);
         end
         if (k == LAT + 1) chk("s4_inflight0", 32'(bus.inflight), 32'h0);
         tick();
      end
      @(negedge clk);
      chk("s4_resume_ready", 32'(bus.req_ready), 32'b1000);
      chk("s4_resume_halted", 32'(bus.halted), 32'h0);
      chk("s4_resume_mul_a", 32'(bus.mul_a), 32'd2);

      // Reset mid-flight: two issues discarded, pointer returns to 0
      do_reset();
      set_op(0, 8'd3, 8'd4);
      set_op(1, 8'd5, 8'd6);
      bus.req_valid = 4'b0011;
      @(negedge clk);
      chk("s5_ready0", 32'(bus.req_ready), 32'b0001);
      tick();
      @(negedge clk);
      chk("s5_ready1", 32'(bus.req_ready), 32'b0010);
      tick();
      bus.req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("s5_rst_inflight", 32'(bus.inflight), 32'h0);
      chk("s5_rst_rsp", 32'(bus.rsp_valid), 32'h0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < LAT + 2; k++) begin
         @(negedge clk);
         chk("s5_no_rsp", 32'(bus.rsp_valid), 32'h0);
         chk("s5_inflight", 32'(bus.inflight), 32'h0);
         tick();
      end
      bus.req_valid = 4'b1111;
      @(negedge clk);
      chk("s5_ptr_reset", 32'(bus.req_ready), 32'b0001);
      tick();
      bus.req_valid = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
